// File: rtl/saph_fpi_arbiter_if.sv
// saph_fpi request/result link. The FPU modport is the responder side and the GPU modport is the initiator side.
interface saph_fpi #(
   parameter int DATA_W = 32,
   parameter int MODE_W = 2
);
   logic              d_trig;
   logic              d_ready;
   logic [DATA_W-1:0] d_lhs;
   logic [DATA_W-1:0] d_rhs;
   logic [MODE_W-1:0] d_mode;
   logic [DATA_W-1:0] q_res;

   modport FPU (input d_trig, d_lhs, d_rhs, d_mode, output d_ready, q_res);
   modport GPU (output d_trig, d_lhs, d_rhs, d_mode, input d_ready, q_res);
endinterface

// File: rtl/saph_fpi_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FPU among several saph_fpi clients.
// Results are steered back to their requesters by a tag pipeline that tracks the FPU latency.
module saph_fpi_arbiter #(
   parameter int clients     = 4,
   parameter int fpu_latency = 2,
   parameter int latency     = 3
) (
   input  logic   clk,
   input  logic   rst,
   saph_fpi.FPU   fpi_in [clients],
   saph_fpi.GPU   fpi_out,
   output logic   busy
);
   localparam int DATA_W = 32;
   localparam int MODE_W = 2;
   localparam int IDW    = (clients > 1) ? $clog2(clients) : 1;

   if (latency != fpu_latency + 1) begin : g_bad_latency
      $error("saph_fpi_arbiter: latency must equal fpu_latency+1");
   end

   logic [clients-1:0] trig;
   logic [clients-1:0] gnt;
   logic [DATA_W-1:0]  lhs [clients];
   logic [DATA_W-1:0]  rhs [clients];
   logic [MODE_W-1:0]  mode [clients];
   logic [DATA_W-1:0]  q_q [clients];

   for (genvar g = 0; g < clients; g++) begin : g_client
      assign trig[g]          = fpi_in[g].d_trig;
      assign lhs[g]           = fpi_in[g].d_lhs;
      assign rhs[g]           = fpi_in[g].d_rhs;
      assign mode[g]          = fpi_in[g].d_mode;
      assign fpi_in[g].d_ready = gnt[g];
      assign fpi_in[g].q_res   = q_q[g];
   end

   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] win;
   logic           any_trig;
   logic           accept;

   // Search from rr_q upward, wrapping to client 0; the first requester found wins.
   always_comb begin
      int  idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < clients; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= clients) idx = idx - clients;
         if (!found && trig[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign any_trig = |trig;
   assign accept   = any_trig && fpi_out.d_ready && !rst;

   always_comb begin
      gnt = '0;
      if (accept) gnt[win] = 1'b1;
   end

   assign fpi_out.d_trig = any_trig;
   assign fpi_out.d_lhs  = any_trig ? lhs[win]  : '0;
   assign fpi_out.d_rhs  = any_trig ? rhs[win]  : '0;
   assign fpi_out.d_mode = any_trig ? mode[win] : '0;

   // Advance past the winner only on a real handshake so a stalled winner keeps priority.
   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (win == IDW'(clients - 1)) ? '0 : win + IDW'(1);
   end

   logic [fpu_latency-1:0] vld_q;
   logic [IDW-1:0]         id_q [fpu_latency];

   always_ff @(posedge clk) begin
      id_q[0] <= win;
      for (int k = 1; k < fpu_latency; k++) id_q[k] <= id_q[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q  <= '0;
         vld_q <= '0;
         for (int i = 0; i < clients; i++) q_q[i] <= '0;
      end else begin
         rr_q     <= rr_d;
         vld_q[0] <= accept;
         for (int k = 1; k < fpu_latency; k++) vld_q[k] <= vld_q[k-1];
         if (vld_q[fpu_latency-1]) q_q[id_q[fpu_latency-1]] <= fpi_out.q_res;
      end
   end

   assign busy = |vld_q;
endmodule

// File: tb/tb_saph_fpi_arbiter.sv
// Bench for saph_fpi_arbiter: vector table, directed corner sequences and a randomized run
// compared every cycle against a queue-based model of grants and result delivery.
module tb_saph_fpi_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic busy;
   always #5 clk = ~clk;

   saph_fpi cli_if [4] ();
   saph_fpi fpu_if ();

   saph_fpi_arbiter #(.clients(4), .fpu_latency(2), .latency(3)) dut (
      .clk(clk), .rst(rst), .fpi_in(cli_if), .fpi_out(fpu_if), .busy(busy)
   );

   logic [3:0]  trig;
   logic [31:0] lhs  [4];
   logic [31:0] rhs  [4];
   logic [1:0]  mode [4];
   logic [3:0]  rdy_o;
   logic [31:0] qres [4];
   logic        fpu_rdy;

   for (genvar g = 0; g < 4; g++) begin : g_cli
      assign cli_if[g].d_trig = trig[g];
      assign cli_if[g].d_lhs  = lhs[g];
      assign cli_if[g].d_rhs  = rhs[g];
      assign cli_if[g].d_mode = mode[g];
      assign rdy_o[g]         = cli_if[g].d_ready;
      assign qres[g]          = cli_if[g].q_res;
   end

   function automatic real f2r(input logic [31:0] b);
      int  e;
      real r;
      e = int'(b[30:23]);
      if (e == 0) return 0.0;
      r = real'({1'b1, b[22:0]}) * (2.0 ** (e - 150));
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      int          ex;
      if (r == 0.0) return 32'h0;
      d  = $realtobits(r);
      ex = int'(d[62:52]) - 1023 + 127;
      return {d[63], ex[7:0], d[51:29]};
   endfunction

   // Mode 0 is a float add; any other mode is a bitwise xor.
   function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
      if (m == 2'd0) return r2f(f2r(a) + f2r(b));
      return a ^ b;
   endfunction

   logic [31:0] f1, f2;
   always @(posedge clk) begin
      f1 <= fpu_fn(fpu_if.d_lhs, fpu_if.d_rhs, fpu_if.d_mode);
      f2 <= f1;
   end
   assign fpu_if.d_ready = fpu_rdy;
   assign fpu_if.q_res   = f2;

   typedef struct {
      int          due;
      int          cli;
      logic [31:0] val;
   } pend_t;
   pend_t       pq [$];
   int          m_rr;
   logic [31:0] m_q [4];
   int          m_win;
   int          cyc;
   int          checks;
   int          errors;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic sample();
      int  w;
      int  idx;
      logic acc;
      @(negedge clk);
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         m_q[pq[0].cli] = pq[0].val;
         void'(pq.pop_front());
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_rr + k) % 4;
         if (w < 0 && trig[idx]) w = idx;
      end
      acc   = (w >= 0) && fpu_rdy && !rst;
      m_win = acc ? w : -1;
      chk("out_trig", 32'(fpu_if.d_trig), 32'(trig != 4'b0));
      chk("out_lhs",  fpu_if.d_lhs,  (w >= 0) ? lhs[w] : 32'h0);
      chk("out_rhs",  fpu_if.d_rhs,  (w >= 0) ? rhs[w] : 32'h0);
      chk("out_mode", 32'(fpu_if.d_mode), (w >= 0) ? 32'(mode[w]) : 32'h0);
      chk("busy",     32'(busy), 32'(pq.size() != 0));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ready%0d", i), 32'(rdy_o[i]), 32'(acc && (w == i)));
         chk($sformatf("q_res%0d", i), qres[i], m_q[i]);
      end
   endtask

   task automatic adv();
      pend_t p;
      @(posedge clk);
      if (rst) begin
         pq.delete();
         for (int i = 0; i < 4; i++) m_q[i] = 32'h0;
         m_rr = 0;
      end else if (m_win >= 0) begin
         p.due = cyc + 3;
         p.cli = m_win;
         p.val = fpu_fn(lhs[m_win], rhs[m_win], mode[m_win]);
         pq.push_back(p);
         m_rr = (m_win + 1) % 4;
      end
      cyc++;
      #1;
   endtask

   task automatic step();
      sample();
      adv();
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 4; i++) begin
         lhs[i]  = $urandom;
         rhs[i]  = $urandom;
         mode[i] = 2'($urandom_range(3, 1));
      end
   endtask

   typedef struct {
      logic       r;
      logic       rdy;
      logic [3:0] tg;
      int         exp_g;
   } vec_t;
   vec_t tbl [14];

   logic [31:0] rv   [5];
   logic [31:0] sums [5];
   logic [31:0] keep [4];

   initial begin
      checks = 0; errors = 0; cyc = 0; m_rr = 0; m_win = -1;
      for (int i = 0; i < 4; i++) m_q[i] = 32'h0;
      rst = 1'b1; fpu_rdy = 1'b1; trig = 4'b0;
      for (int i = 0; i < 4; i++) begin lhs[i] = 0; rhs[i] = 0; mode[i] = 0; end
      @(posedge clk); #1;

      // Reset held two cycles under random traffic, then quiet cycles.
      for (int c = 0; c < 2; c++) begin
         rst = 1'b1; trig = 4'($urandom); fpu_rdy = 1'($urandom); rand_ops();
         step();
      end
      rst = 1'b0; trig = 4'b0; fpu_rdy = 1'b1;
      for (int c = 0; c < 5; c++) step();

      tbl[0]  = '{1'b1, 1'b1, 4'b1111, -1};
      tbl[1]  = '{1'b0, 1'b1, 4'b1111,  0};
      tbl[2]  = '{1'b0, 1'b1, 4'b1111,  1};
      tbl[3]  = '{1'b0, 1'b1, 4'b1111,  2};
      tbl[4]  = '{1'b0, 1'b1, 4'b1111,  3};
      tbl[5]  = '{1'b0, 1'b1, 4'b1111,  0};
      tbl[6]  = '{1'b0, 1'b1, 4'b1111,  1};
      tbl[7]  = '{1'b0, 1'b1, 4'b0001,  0};
      tbl[8]  = '{1'b0, 1'b0, 4'b1010, -1};
      tbl[9]  = '{1'b0, 1'b0, 4'b1010, -1};
      tbl[10] = '{1'b0, 1'b0, 4'b1010, -1};
      tbl[11] = '{1'b0, 1'b1, 4'b1010,  1};
      tbl[12] = '{1'b0, 1'b1, 4'b1010,  3};
      tbl[13] = '{1'b0, 1'b1, 4'b0000, -1};
      for (int v = 0; v < 14; v++) begin
         rst = tbl[v].r; fpu_rdy = tbl[v].rdy; trig = tbl[v].tg; rand_ops();
         sample();
         chk($sformatf("tbl_grant%0d", v), 32'(rdy_o), (tbl[v].exp_g < 0) ? 32'h0 : 32'(1 << tbl[v].exp_g));
         adv();
      end
      trig = 4'b0;
      for (int c = 0; c < 4; c++) step();

      // Single float add on client 2.
      for (int i = 0; i < 4; i++) keep[i] = m_q[i];
      trig = 4'b0100; lhs[2] = 32'h3F800000; rhs[2] = 32'h40000000; mode[2] = 2'd0;
      sample();
      chk("single_ready", 32'(rdy_o), 32'h4);
      chk("single_lhs", fpu_if.d_lhs, 32'h3F800000);
      adv();
      trig = 4'b0;
      step(); step();
      sample();
      chk("single_res", qres[2], 32'h40400000);
      for (int i = 0; i < 4; i++) if (i != 2) chk($sformatf("single_keep%0d", i), qres[i], keep[i]);
      adv();

      // Sole requester streaming five consecutive float adds.
      rv[0] = 32'h3F800000; rv[1] = 32'h40000000; rv[2] = 32'h40400000; rv[3] = 32'h40800000; rv[4] = 32'h40A00000;
      sums[0] = 32'h40000000; sums[1] = 32'h40400000; sums[2] = 32'h40800000; sums[3] = 32'h40A00000; sums[4] = 32'h40C00000;
      lhs[3] = 32'h3F800000; mode[3] = 2'd0;
      for (int k = 0; k < 8; k++) begin
         trig   = (k < 5) ? 4'b1000 : 4'b0000;
         rhs[3] = rv[(k < 5) ? k : 4];
         sample();
         if (k < 5) chk($sformatf("stream_ready%0d", k), 32'(rdy_o), 32'h8);
         if (k >= 3) chk($sformatf("stream_res%0d", k - 3), qres[3], sums[k-3]);
         adv();
      end

      // Mid-flight reset discards the in-flight result.
      rst = 1'b1; trig = 4'b0; step();
      rst = 1'b0; step(); step();
      trig = 4'b0001; lhs[0] = 32'h12345678; rhs[0] = 32'h0F0F0F0F; mode[0] = 2'd1;
      sample();
      chk("mid_grant", 32'(rdy_o), 32'h1);
      adv();
      rst = 1'b1; trig = 4'b0; step();
      rst = 1'b0;
      sample();
      chk("mid_busy", 32'(busy), 32'h0);
      adv();
      sample();
      chk("mid_q0", qres[0], 32'h0);
      adv();
      for (int c = 0; c < 3; c++) step();

      // Randomized traffic with occasional stalls and resets.
      for (int c = 0; c < 400; c++) begin
         rst     = ($urandom_range(49, 0) == 0);
         fpu_rdy = ($urandom_range(3, 0) != 0);
         trig    = 4'($urandom);
         rand_ops();
         step();
      end
      rst = 1'b0; trig = 4'b0;
      for (int c = 0; c < 5; c++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
